// File: rtl/sub_32bit_pipe_if.sv
// Handshake bundle for sub_32bit_pipe.
//   slave  : the subtractor's view (takes operands, presents results)
//   master : the surrounding logic's view (supplies operands, consumes results)
// Signals: in_valid/in_ready/A/B on the operand side, out_valid/out_ready/D/BOUT
// on the result side. OVF exists only when SUB_OVF_FLAG_EN is defined.
interface sub_32bit_pipe_if #(
   parameter int HALF_W = 16
);
   logic                  in_valid;
   logic                  in_ready;
   logic [2*HALF_W-1:0]   A;
   logic [2*HALF_W-1:0]   B;
   logic                  out_valid;
   logic                  out_ready;
   logic [2*HALF_W-1:0]   D;
   logic                  BOUT;
`ifdef SUB_OVF_FLAG_EN
   logic                  OVF;

   modport slave  (input  in_valid, A, B, out_ready,
                   output in_ready, out_valid, D, BOUT, OVF);
   modport master (output in_valid, A, B, out_ready,
                   input  in_ready, out_valid, D, BOUT, OVF);
`else
   modport slave  (input  in_valid, A, B, out_ready,
                   output in_ready, out_valid, D, BOUT);
   modport master (output in_valid, A, B, out_ready,
                   input  in_ready, out_valid, D, BOUT);
`endif
endinterface

// File: rtl/sub_32bit_pipe.sv
// Two-stage pipelined unsigned subtractor: D = A - B mod 2^(2*HALF_W), BOUT = (A < B).
// Stage 1 resolves the low half and registers the inter-half borrow; stage 2
// resolves the high half. Valid/ready on both sides with full backpressure.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    sub_32bit_pipe_if.slave (in_valid/in_ready/A/B, out_valid/out_ready/D/BOUT)
// Optional: define SUB_OVF_FLAG_EN to add the registered signed-overflow flag OVF.
module sub_32bit_pipe #(
   parameter int HALF_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   sub_32bit_pipe_if.slave    bus
);

   localparam int W = 2 * HALF_W;

   logic              s1_valid;
   logic [HALF_W-1:0] s1_dlo;
   logic              s1_b16;
   logic [HALF_W-1:0] s1_ahi;
   logic [HALF_W-1:0] s1_bhi;

   logic              out_valid_q;
   logic [W-1:0]      d_q;
   logic              bout_q;

   logic              s1_en;
   logic              s2_en;
   logic [HALF_W:0]   lo_sum;
   logic [HALF_W:0]   hi_sum;

   assign s2_en = ~out_valid_q | bus.out_ready;
   assign s1_en = ~s1_valid | s2_en;

   // Subtraction as addition of the one's complement; the carry out is the
   // inverted borrow.
   assign lo_sum = {1'b0, bus.A[HALF_W-1:0]} + {1'b0, ~bus.B[HALF_W-1:0]}
                 + {{HALF_W{1'b0}}, 1'b1};
   assign hi_sum = {1'b0, s1_ahi} + {1'b0, ~s1_bhi} + {{HALF_W{1'b0}}, ~s1_b16};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_dlo   <= '0;
         s1_b16   <= 1'b0;
         s1_ahi   <= '0;
         s1_bhi   <= '0;
      end else if (s1_en) begin
         s1_valid <= bus.in_valid;
         // Data regs load only on an actual transfer so don't-care operands
         // never reach the pipeline.
         if (bus.in_valid) begin
            s1_dlo <= lo_sum[HALF_W-1:0];
            s1_b16 <= ~lo_sum[HALF_W];
            s1_ahi <= bus.A[W-1:HALF_W];
            s1_bhi <= bus.B[W-1:HALF_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         d_q         <= '0;
         bout_q      <= 1'b0;
      end else if (s2_en) begin
         out_valid_q <= s1_valid;
         // On a bubble the result registers keep their last value.
         if (s1_valid) begin
            d_q    <= {hi_sum[HALF_W-1:0], s1_dlo};
            bout_q <= ~hi_sum[HALF_W];
         end
      end
   end

`ifdef SUB_OVF_FLAG_EN
   logic ovf_q;

   // Sign bits of A and B travel in s1_ahi/s1_bhi; overflow when the operand
   // signs differ and the result sign differs from the minuend sign.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (s2_en && s1_valid) begin
         ovf_q <= (s1_ahi[HALF_W-1] != s1_bhi[HALF_W-1])
                & (hi_sum[HALF_W-1] != s1_ahi[HALF_W-1]);
      end
   end

   assign bus.OVF = ovf_q;
`endif

   assign bus.in_ready  = s1_en;
   assign bus.out_valid = out_valid_q;
   assign bus.D         = d_q;
   assign bus.BOUT      = bout_q;

endmodule

// File: tb/tb_sub_32bit_pipe.sv
module tb_sub_32bit_pipe;

   typedef struct packed {
      logic [31:0] d;
      logic        bout;
      logic        ovf;
   } res_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_d;
      logic        exp_bout;
      logic        exp_ovf;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sub_32bit_pipe_if #(.HALF_W(16)) bus ();

   sub_32bit_pipe #(.HALF_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   n_vec  = 0;
   int   n_fail = 0;
   res_t exp_q[$];
   logic acc;
   logic got;

   // Reference: plain 33-bit arithmetic and signed-overflow rule.
   function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
      res_t        r;
      logic [32:0] diff;
      diff   = {1'b0, a} - {1'b0, b};
      r.d    = diff[31:0];
      r.bout = (a < b);
      r.ovf  = (a[31] != b[31]) && (diff[31] != a[31]);
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive, sample before the edge, score, advance past the edge.
   task automatic cycle(input logic iv, input logic [31:0] a, input logic [31:0] b,
                        input logic ordy);
      res_t e;
      bus.in_valid  = iv;
      bus.A         = a;
      bus.B         = b;
      bus.out_ready = ordy;
      #1;
      acc = iv & bus.in_ready & rst_n;
      got = bus.out_valid & ordy & rst_n;
      if (acc) exp_q.push_back(model(a, b));
      if (got) begin
         check("result_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("D", 64'(bus.D), 64'(e.d));
            check("BOUT", 64'(bus.BOUT), 64'(e.bout));
`ifdef SUB_OVF_FLAG_EN
            check("OVF", 64'(bus.OVF), 64'(e.ovf));
`endif
         end
      end
      @(posedge clk);
      #1;
   endtask

   vec_t        tab[8];
   logic [31:0] bp_a[4];
   logic [31:0] bp_b[4];
   res_t        r0;

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.A         = '0;
      bus.B         = '0;

      tab[0] = '{32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b0};
      tab[1] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0};
      tab[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0};
      tab[3] = '{32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0};
      tab[4] = '{32'h1234_5678, 32'h1234_5679, 32'hFFFF_FFFF, 1'b1, 1'b0};
      tab[5] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
      tab[6] = '{32'h0000_FFFF, 32'h0001_0000, 32'hFFFF_FFFF, 1'b1, 1'b0};
      tab[7] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1};

      // Reset held for 3 cycles
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_D", 64'(bus.D), 64'd0);
      check("rst_BOUT", 64'(bus.BOUT), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef SUB_OVF_FLAG_EN
      check("rst_OVF", 64'(bus.OVF), 64'd0);
`endif
      @(posedge clk);
      #1;

      // Table vectors, one at a time: latency exactly 2, result holds after consumption
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, tab[i].a, tab[i].b, 1'b1);
         check("tab_accept", 64'(acc), 64'd1);
         cycle(1'b0, 32'h0, 32'h0, 1'b1);
         check("tab_lat1_no_valid", 64'(got), 64'd0);
         cycle(1'b0, 32'h0, 32'h0, 1'b1);
         check("tab_lat2_valid", 64'(got), 64'd1);
         check("tab_bubble_out_valid", 64'(bus.out_valid), 64'd0);
         check("tab_D", 64'(bus.D), 64'(tab[i].exp_d));
         check("tab_BOUT", 64'(bus.BOUT), 64'(tab[i].exp_bout));
`ifdef SUB_OVF_FLAG_EN
         check("tab_OVF", 64'(bus.OVF), 64'(tab[i].exp_ovf));
`endif
      end

      // Backpressure: 2 accepts fill the pipe, then in_ready drops and D holds
      bp_a[0] = 32'h0003_0000; bp_b[0] = 32'h0000_0007;
      bp_a[1] = 32'h0000_0010; bp_b[1] = 32'h0000_0020;
      bp_a[2] = 32'hDEAD_BEEF; bp_b[2] = 32'h1234_5678;
      bp_a[3] = 32'h0000_0000; bp_b[3] = 32'h0000_0000;
      r0 = model(bp_a[0], bp_b[0]);
      cycle(1'b1, bp_a[0], bp_b[0], 1'b0);
      check("bp_acc0", 64'(acc), 64'd1);
      cycle(1'b1, bp_a[1], bp_b[1], 1'b0);
      check("bp_acc1", 64'(acc), 64'd1);
      for (int i = 0; i < 2; i++) begin
         cycle(1'b1, bp_a[2], bp_b[2], 1'b0);
         check("bp_full_in_ready", 64'(acc), 64'd0);
         check("bp_out_valid", 64'(bus.out_valid), 64'd1);
         check("bp_D_hold", 64'(bus.D), 64'(r0.d));
      end
      begin
         int k;
         int recv;
         k = 2;
         recv = 0;
         for (int c = 0; c < 20 && recv < 4; c++) begin
            if (k < 4) cycle(1'b1, bp_a[k], bp_b[k], 1'b1);
            else       cycle(1'b0, 32'h0, 32'h0, 1'b1);
            if (acc) k++;
            if (got) recv++;
         end
         check("bp_recv_count", 64'(recv), 64'd4);
      end

      // Random streaming with random in_valid/out_ready
      begin
         int          accepted;
         logic        have;
         logic [31:0] ra;
         logic [31:0] rb;
         accepted = 0;
         have = 1'b0;
         ra = '0;
         rb = '0;
         for (int c = 0; c < 6000 && accepted < 1000; c++) begin
            if (!have) begin
               ra = $urandom;
               rb = $urandom;
               case ($urandom_range(0, 7))
                  0: ra = rb;
                  1: ra = 32'h0;
                  2: rb = 32'hFFFF_FFFF;
                  3: rb = {ra[31:16], $urandom_range(0, 65535) & 16'hFFFF};
                  default: ;
               endcase
               have = 1'b1;
            end
            cycle(($urandom_range(0, 3) != 0), ra, rb, ($urandom_range(0, 3) != 0));
            if (acc) begin
               accepted++;
               have = 1'b0;
            end
         end
         check("rand_accepted", 64'(accepted), 64'd1000);
         for (int c = 0; c < 10 && exp_q.size() != 0; c++) cycle(1'b0, 32'h0, 32'h0, 1'b1);
         check("rand_drained", 64'(exp_q.size()), 64'd0);
      end

      // Reset with 2 results in flight; in_valid during reset is ignored
      cycle(1'b1, 32'h0000_1111, 32'h0000_0001, 1'b0);
      cycle(1'b1, 32'h0000_2222, 32'h0000_0002, 1'b0);
      check("mid_full", 64'(bus.out_valid), 64'd1);
      rst_n = 1'b0;
      cycle(1'b1, 32'h0000_3333, 32'h0000_0003, 1'b1);
      rst_n = 1'b1;
      exp_q.delete();
      check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("mid_rst_D", 64'(bus.D), 64'd0);
      check("mid_rst_BOUT", 64'(bus.BOUT), 64'd0);
      check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 32'h0, 32'h0, 1'b1);
         check("mid_no_stale", 64'(got), 64'd0);
      end
      cycle(1'b1, 32'h0000_0000, 32'h0000_0001, 1'b1);
      for (int c = 0; c < 10 && exp_q.size() != 0; c++) cycle(1'b0, 32'h0, 32'h0, 1'b1);
      check("post_rst_drained", 64'(exp_q.size()), 64'd0);
      check("post_rst_D", 64'(bus.D), 64'hFFFF_FFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
